// File: rtl/bloom_line_ager_pkg.sv
// bloom_line_ager_pkg: shared helpers for the bloom line aging engine.
package bloom_line_ager_pkg;

    function automatic int log2c(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

endpackage

// File: rtl/bloom_bucket_shifter.sv
// bloom_bucket_shifter: combinational bucket-granular right shift of the bloom field.
module bloom_bucket_shifter #(
    parameter int BLOOM_W   = 48,
    parameter int BUCKET_SZ = 4,
    parameter int AGE_W     = 4
)(
    input  logic [BLOOM_W-1:0] bloom,
    input  logic [AGE_W-1:0]   age,
    output logic [BLOOM_W-1:0] bloom_out
);

    // age==NUM_BUCKETS shifts by the full field width, which yields all zeros
    assign bloom_out = bloom >> (int'(age) * BUCKET_SZ);

endmodule

// File: rtl/bloom_line_ager.sv
// bloom_line_ager: two-stage aging pipeline for time-decaying bloom lines,
// owning the bucket/loop timebase and a saturating future-stamp error counter.
module bloom_line_ager
    import bloom_line_ager_pkg::*;
#(
    parameter int DATA_WIDTH     = 64,
    parameter int NUM_BUCKETS    = 12,
    parameter int BUCKET_SZ      = 4,
    parameter int BLOOM_INIT_POS = 16,
    parameter int ERR_CNT_W      = 16,
    localparam int BITS_SHIFT    = log2c(NUM_BUCKETS),
    localparam int LOOP_BITS     = BLOOM_INIT_POS - BITS_SHIFT
)(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  tick,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_err,
    output logic [BITS_SHIFT-1:0] cur_bucket,
    output logic [LOOP_BITS-1:0]  cur_loop,
    output logic [ERR_CNT_W-1:0]  err_count,
    input  logic                  err_count_clr
);

    localparam int BLOOM_W = DATA_WIDTH - BLOOM_INIT_POS;
    localparam int AGE_W   = LOOP_BITS + BITS_SHIFT + 1;
    localparam int SAT_W   = log2c(NUM_BUCKETS + 1);

    logic                      s1_valid, s1_future, s1_adv, wrap, future;
    logic [DATA_WIDTH-1:0]     s1_data;
    logic [SAT_W-1:0]          s1_age;
    logic [BLOOM_INIT_POS-1:0] s1_stamp;
    logic [BITS_SHIFT-1:0]     d_bucket;
    logic [LOOP_BITS-1:0]      d_loop, ld;
    logic [AGE_W-1:0]          age_full;
    logic [BLOOM_W-1:0]        bloom_aged;

    assign s1_adv   = !out_valid || out_ready;
    assign in_ready = !s1_valid || s1_adv;
    assign wrap     = cur_bucket == BITS_SHIFT'(NUM_BUCKETS - 1);

    assign d_bucket = in_data[BLOOM_INIT_POS-1 -: BITS_SHIFT];
    assign d_loop   = in_data[LOOP_BITS-1:0];
    assign ld       = cur_loop - d_loop;
    // half the loop space behind counts as past, the other half as future
    assign future   = ld[LOOP_BITS-1] || (ld == '0 && d_bucket > cur_bucket)
                   || {1'b0, d_bucket} >= (BITS_SHIFT+1)'(NUM_BUCKETS);
    assign age_full = AGE_W'(ld) * AGE_W'(NUM_BUCKETS) + AGE_W'(cur_bucket) - AGE_W'(d_bucket);

    bloom_bucket_shifter #(.BLOOM_W(BLOOM_W), .BUCKET_SZ(BUCKET_SZ), .AGE_W(SAT_W)) u_shift (
        .bloom     (s1_data[DATA_WIDTH-1:BLOOM_INIT_POS]),
        .age       (s1_age),
        .bloom_out (bloom_aged)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_bucket <= '0;
            cur_loop   <= '0;
        end else if (tick) begin
            cur_bucket <= wrap ? '0 : cur_bucket + 1'b1;
            if (wrap) cur_loop <= cur_loop + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            s1_future <= 1'b0;
            s1_data   <= '0;
            s1_age    <= '0;
            s1_stamp  <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_err   <= 1'b0;
        end else begin
            if (in_ready) begin
                s1_valid <= in_valid;
                if (in_valid) begin
                    s1_data   <= in_data;
                    s1_future <= future;
                    s1_age    <= age_full >= AGE_W'(NUM_BUCKETS) ? SAT_W'(NUM_BUCKETS) : age_full[SAT_W-1:0];
                    s1_stamp  <= {cur_bucket, cur_loop};
                end
            end
            if (s1_adv) begin
                out_valid <= s1_valid;
                if (s1_valid) begin
                    out_data <= s1_future ? s1_data : {bloom_aged, s1_stamp};
                    out_err  <= s1_future;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) err_count <= '0;
        else if (err_count_clr) err_count <= '0;
        else if (out_valid && out_ready && out_err && err_count != '1) err_count <= err_count + 1'b1;
    end

endmodule

// File: tb/tb_bloom_line_ager.sv
// tb_bloom_line_ager: directed vector table plus backpressure, clear and reset sequences.
module tb_bloom_line_ager;

    logic        clk = 0, rst_n = 0, tick = 0, in_valid = 0, out_ready = 1, err_count_clr = 0;
    logic [63:0] in_data = '0;
    logic        in_ready, out_valid, out_err;
    logic [63:0] out_data;
    logic [3:0]  cur_bucket;
    logic [11:0] cur_loop;
    logic [15:0] err_count;
    int checks = 0, failures = 0;

    bloom_line_ager dut (
        .clk(clk), .rst_n(rst_n), .tick(tick), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_err(out_err), .cur_bucket(cur_bucket), .cur_loop(cur_loop),
        .err_count(err_count), .err_count_clr(err_count_clr)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        int          ticks;
        logic [63:0] din;
        logic [63:0] dout;
        logic        err;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h want=%h", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 0; tick = 0; in_valid = 0; out_ready = 1; err_count_clr = 0;
        repeat (2) @(negedge clk);
        rst_n = 1;
    endtask

    task automatic tick_n(input int n);
        repeat (n) begin
            @(negedge clk);
            tick = 1;
        end
        @(negedge clk);
        tick = 0;
    endtask

    task automatic send_check(input string nm, input logic [63:0] din, input logic [63:0] dout,
                              input logic err, input logic [15:0] cnt, input logic tick_acc, input logic clr);
        int n;
        @(negedge clk);
        in_valid = 1; in_data = din; tick = tick_acc; out_ready = 1;
        @(negedge clk);
        in_valid = 0; tick = 0;
        n = 1;
        while (!out_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk({nm, "_lat"}, 64'(n), 64'd2);
        chk({nm, "_data"}, out_data, dout);
        chk({nm, "_err"}, out_err, err);
        err_count_clr = clr;
        @(negedge clk);
        err_count_clr = 0;
        chk({nm, "_cnt"}, err_count, cnt);
    endtask

    function automatic logic [63:0] line(input int i);
        return {48'h0101_0101_0101 * 48'(i + 1), 16'h0000};
    endfunction

    initial begin
        int i, nrx;
        logic [63:0] held;
        vecs[0] = '{"v1_age3",   5,  64'hFFFF_FFFF_FFFF_2000, 64'h000F_FFFF_FFFF_5000, 1'b0};
        vecs[1] = '{"v2_age2",   13, 64'h1234_5678_9ABC_B000, 64'h0012_3456_789A_1001, 1'b0};
        vecs[2] = '{"v3_sat",    12, 64'hFFFF_FFFF_FFFF_0000, 64'h0000_0000_0000_0001, 1'b0};
        vecs[3] = '{"v3_sat37",  87, 64'hFFFF_FFFF_FFFF_0000, 64'h0000_0000_0000_3007, 1'b0};
        vecs[4] = '{"v4_future", 5,  64'hDEAD_BEEF_CAFE_7000, 64'hDEAD_BEEF_CAFE_7000, 1'b1};
        vecs[5] = '{"v5_wrap",   0,  64'hABCD_EF01_2345_BFFF, 64'h0ABC_DEF0_1234_0000, 1'b0};
        vecs[6] = '{"bkt_ge12",  14, 64'h5555_AAAA_5555_C000, 64'h5555_AAAA_5555_C000, 1'b1};
        vecs[7] = '{"ld_half",   0,  64'h1111_2222_3333_0800, 64'h1111_2222_3333_0800, 1'b1};
        vecs[8] = '{"age0",      5,  64'h8765_4321_0FED_5000, 64'h8765_4321_0FED_5000, 1'b0};
        vecs[9] = '{"age11",     11, 64'hFFFF_FFFF_FFFF_0000, 64'h0000_0000_000F_B000, 1'b0};

        do_reset();
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_err", out_err, 0);
        chk("rst_cur", {cur_bucket, cur_loop}, 0);
        chk("rst_err_count", err_count, 0);

        foreach (vecs[v]) begin
            do_reset();
            tick_n(vecs[v].ticks);
            chk({vecs[v].name, "_bucket"}, cur_bucket, 64'(vecs[v].ticks % 12));
            chk({vecs[v].name, "_loop"}, cur_loop, 64'(vecs[v].ticks / 12));
            send_check(vecs[v].name, vecs[v].din, vecs[v].dout, vecs[v].err, 16'(vecs[v].err), 1'b0, 1'b0);
        end

        // future line after a flagged one, clear coincident with the increment
        do_reset();
        tick_n(5);
        send_check("clr_first", 64'hDEAD_BEEF_CAFE_7000, 64'hDEAD_BEEF_CAFE_7000, 1'b1, 16'd1, 1'b0, 1'b0);
        send_check("clr_coinc", 64'h0F0F_0F0F_0F0F_9000, 64'h0F0F_0F0F_0F0F_9000, 1'b1, 16'd0, 1'b0, 1'b1);
        send_check("clr_after", 64'h0F0F_0F0F_0F0F_9000, 64'h0F0F_0F0F_0F0F_9000, 1'b1, 16'd1, 1'b0, 1'b0);

        // tick on the acceptance cycle uses the pre-tick timestamp
        do_reset();
        send_check("tick_acc", 64'h0123_4567_89AB_0000, 64'h0123_4567_89AB_0000, 1'b0, 16'd0, 1'b1, 1'b0);
        chk("tick_acc_bucket", cur_bucket, 1);

        // backpressure stream of 8 lines
        do_reset();
        i = 0; nrx = 0; held = '0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            out_ready = !(k >= 3 && k <= 12);
            in_valid = i < 8;
            in_data = line(i);
            #1;
            if (k == 6) chk("bp_in_ready_low", in_ready, 0);
            if (k > 3 && k <= 12) chk("bp_hold", out_data, held);
            if (out_valid) held = out_data;
            if (out_valid && out_ready) begin
                if (nrx < 8) chk($sformatf("bp_order%0d", nrx), out_data, line(nrx));
                nrx++;
            end
            if (in_valid && in_ready) i++;
        end
        in_valid = 0;
        chk("bp_count", 64'(nrx), 64'd8);

        // reset mid-stream drops in-flight lines
        do_reset();
        tick_n(3);
        @(negedge clk);
        in_valid = 1; in_data = line(0); out_ready = 0;
        @(negedge clk);
        in_data = line(1);
        @(negedge clk);
        chk("mid_pre_valid", out_valid, 1);
        rst_n = 0; in_valid = 0;
        #1;
        chk("mid_out_valid", out_valid, 0);
        chk("mid_cur", {cur_bucket, cur_loop}, 0);
        chk("mid_in_ready", in_ready, 1);
        @(negedge clk);
        rst_n = 1; out_ready = 1;
        repeat (3) @(negedge clk);
        chk("mid_drop", out_valid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
